bcd_serial_add_ctrl: RTL and testbench
======================================

// Module: bcd_serial_add_ctrl
// PURPOSE
//  Sequencer for the single-digit BCD adder (a[3:0], b[3:0], cin -> sum[3:0], carry).
//  Adds two DIGITS-digit packed-BCD operands by issuing one digit per clock through the adder,
//  least-significant digit first, and rippling the carry between digits in a register.
//  Sits between a requester (start/done handshake) and one combinational digit-adder instance.
// PARAMETERS
//  DIGITS   4   number of BCD digits per operand; legal range 2..8
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          synchronous, active-high reset
//  start      in   1          request pulse; sampled only in IDLE
//  op_a       in   4*DIGITS   operand A, packed BCD, digit 0 = op_a[3:0]
//  op_b       in   4*DIGITS   operand B, packed BCD
//  cin        in   1          carry into digit 0
//  dig_a      out  4          to adder a
//  dig_b      out  4          to adder b
//  dig_cin    out  1          to adder cin
//  dig_sum    in   4          from adder sum (combinational, same cycle)
//  dig_carry  in   1          from adder carry
//  busy       out  1          high from the cycle after start is accepted until done
//  done       out  1          one-cycle pulse; result valid
//  sum        out  4*DIGITS   packed-BCD result; held until next accepted start
//  cout       out  1          carry out of the top digit
//  err        out  1          operand contained a nibble > 9; qualified by done
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): state=IDLE; busy, done, cout, err, sum, dig_a, dig_b, dig_cin,
//    digit index and carry register all 0. Reset mid-operation aborts with no done pulse.
//  FSM states: IDLE, RUN, DONE.
//  IDLE: dig_* = 0. On start=1, latch op_a, op_b, cin into internal registers; clear sum, cout, err;
//    set idx=0.
//    If any nibble of op_a or op_b is > 9: set err=1 and go to DONE (no RUN cycles).
//    Otherwise go to RUN.
//  RUN: dig_a = A[idx], dig_b = B[idx], and dig_cin = carry register. On the clock edge:
//    sum[idx] <= dig_sum; carry register <= dig_carry.
//    If idx==DIGITS-1: cout <= dig_carry, go to DONE. Otherwise idx <= idx+1.
//  DONE: done=1 for exactly this cycle, busy=0, dig_* = 0. Next state is always IDLE.
//  busy=1 in RUN only.
//  Latency: start accepted at edge N; RUN occupies cycles N+1..N+DIGITS; done is high in cycle
//    N+DIGITS+1. With the error path, done is high in cycle N+1.
//  start while not in IDLE: ignored, with no effect on the operation in flight.
//    Back-to-back starts: start may be accepted in the IDLE cycle that follows DONE.
//  The controller does not correct adder output. It trusts dig_sum/dig_carry as valid BCD.
//  Operand changes after acceptance have no effect, because operands are registered.
//  On err: sum=0 and cout=0.
//  Index width: $clog2(DIGITS). Index never exceeds DIGITS-1 (no wrap).
// TESTING (DIGITS=4, with a behavioural BCD digit adder attached)
//  1. op_a=16'h0047, op_b=16'h0053, cin=0 -> sum=16'h0100, cout=0, err=0; done 5 cycles after start edge.
//  2. op_a=16'h9999, op_b=16'h0001, cin=0 -> sum=16'h0000, cout=1; carry ripples through all 4 digits.
//  3. op_a=16'h0004, op_b=16'h0003, cin=1 -> sum=16'h0008, cout=0;
//     then back-to-back 16'h0009+16'h0005 -> sum=16'h0014.
//  4. op_a=16'h00A0, op_b=16'h0001 -> done 1 cycle after start, err=1, sum=0, cout=0, busy never high.
//  5. start pulsed again in the 2nd RUN cycle with different operands -> ignored; result of test 1 unchanged.
//  6. rst asserted in the 3rd RUN cycle -> next cycle IDLE, all outputs 0, no done.
//     A new start afterwards completes correctly.

Source files
------------

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial sequencer for a single-digit BCD adder: issues one operand digit per
// clock, LSD first, rippling the carry through a register between digits.
module bcd_serial_add_ctrl #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   op_a,
    input  logic [4*DIGITS-1:0]   op_b,
    input  logic                  cin,
    output logic [3:0]            dig_a,
    output logic [3:0]            dig_b,
    output logic                  dig_cin,
    input  logic [3:0]            dig_sum,
    input  logic                  dig_carry,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            err_q, err_d;
    logic            bad_nibble;
    logic            last_digit;

    always_comb begin
        bad_nibble = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (op_a[4*i +: 4] > 4'd9 || op_b[4*i +: 4] > 4'd9) begin
                bad_nibble = 1'b1;
            end
        end
    end

    assign last_digit = (idx_q == IW'(DIGITS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = bad_nibble ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_digit) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: the adder is driven only while running; the digit mux uses constant selects
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        dig_a   = '0;
        dig_b   = '0;
        dig_cin = 1'b0;
        case (state_q)
            RUN: begin
                busy    = 1'b1;
                dig_cin = carry_q;
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    if (idx_q == IW'(i)) begin
                        dig_a = a_q[4*i +: 4];
                        dig_b = b_q[4*i +: 4];
                    end
                end
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    carry_d = cin;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    err_d   = bad_nibble;
                    idx_d   = '0;
                end
            end
            RUN: begin
                carry_d = dig_carry;
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    if (idx_q == IW'(i)) begin
                        sum_d[4*i +: 4] = dig_sum;
                    end
                end
                if (last_digit) begin
                    cout_d = dig_carry;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Bench for bcd_serial_add_ctrl with a behavioural BCD digit adder attached; results are
// compared against decimal arithmetic on the operands.
module tb_bcd_serial_add_ctrl;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 4 * DIGITS;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  op_a, op_b;
    logic          cin;
    logic [3:0]    dig_a, dig_b, dig_sum;
    logic          dig_cin, dig_carry;
    logic          busy, done, cout, err;
    logic [W-1:0]  sum;

    int unsigned pass_cnt = 0;
    int unsigned fail_cnt = 0;

    always #5 clk = ~clk;

    bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
        .dig_a(dig_a), .dig_b(dig_b), .dig_cin(dig_cin), .dig_sum(dig_sum),
        .dig_carry(dig_carry), .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
    );

    // Behavioural single-digit BCD adder
    always_comb begin
        int unsigned s;
        s = int'(dig_a) + int'(dig_b) + int'(dig_cin);
        dig_carry = (s > 9);
        dig_sum   = (s > 9) ? 4'(s - 10) : 4'(s);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_valid(input logic [W-1:0] v);
        logic [3:0] nib;
        for (int i = 0; i < int'(DIGITS); i++) begin
            nib = v[4*i +: 4];
            if (nib > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic longint unsigned to_dec(input logic [W-1:0] v);
        longint unsigned r = 0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input longint unsigned v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Issue one operation starting at the next falling edge; returns in the IDLE cycle after done.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input bit inject);
        longint unsigned modv, total;
        logic [W-1:0]    exp_sum;
        logic            exp_cout, exp_err;
        int unsigned     exp_lat, k;
        bit              got;

        modv = 1;
        for (int i = 0; i < int'(DIGITS); i++) modv = modv * 10;
        exp_err = !(is_valid(a) && is_valid(b));
        if (exp_err) begin
            exp_sum = '0; exp_cout = 1'b0; exp_lat = 1;
        end else begin
            total    = to_dec(a) + to_dec(b) + longint'(c);
            exp_sum  = to_bcd(total % modv);
            exp_cout = (total >= modv);
            exp_lat  = DIGITS + 1;
        end

        @(negedge clk);
        start = 1'b1; op_a = a; op_b = b; cin = c;
        @(posedge clk); #1;
        start = 1'b0;
        op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom);

        k = 1; got = 1'b0;
        while (k <= 20 && !got) begin
            if (done) begin
                got = 1'b1;
            end else begin
                check("busy_run", busy, 1'b1);
                if (inject && k == 2) begin
                    @(negedge clk);
                    start = 1'b1; op_a = 16'h1111; op_b = 16'h2222; cin = 1'b1;
                    @(posedge clk); #1;
                    start = 1'b0;
                end else begin
                    @(posedge clk); #1;
                end
                k++;
            end
        end
        check("done_seen", got, 1'b1);
        if (got) begin
            check("latency",   k,       exp_lat);
            check("busy_done", busy,    1'b0);
            check("sum",       sum,     exp_sum);
            check("cout",      cout,    exp_cout);
            check("err",       err,     exp_err);
            check("dig_idle",  {dig_a, dig_b, dig_cin}, 9'h0);
            @(posedge clk); #1;
            check("done_pulse", done, 1'b0);
            check("sum_held",   sum,  exp_sum);
        end
    endtask

    function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
        logic [W-1:0] r;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (allow_bad && $urandom_range(0, 7) == 0) r[4*i +: 4] = 4'($urandom_range(10, 15));
            else                                         r[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return r;
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sum",  sum,  '0);
        check("rst_cout", cout, 1'b0);
        check("rst_err",  err,  1'b0);
        check("rst_dig",  {dig_a, dig_b, dig_cin}, 9'h0);
        @(negedge clk);
        rst = 1'b0;

        do_op(16'h0047, 16'h0053, 1'b0, 1'b0);
        do_op(16'h9999, 16'h0001, 1'b0, 1'b0);
        do_op(16'h0004, 16'h0003, 1'b1, 1'b0);
        do_op(16'h0009, 16'h0005, 1'b0, 1'b0);
        do_op(16'h00A0, 16'h0001, 1'b0, 1'b0);
        do_op(16'h0047, 16'h0053, 1'b0, 1'b1);
        do_op(16'h9999, 16'h9999, 1'b1, 1'b0);

        // Reset during the third RUN cycle aborts the operation
        @(negedge clk);
        start = 1'b1; op_a = 16'h1234; op_b = 16'h5678; cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_busy_pre", busy, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_sum",  sum,  '0);
        check("abort_cout", cout, 1'b0);
        check("abort_err",  err,  1'b0);
        check("abort_dig",  {dig_a, dig_b, dig_cin}, 9'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_nodone", done, 1'b0);
        do_op(16'h1234, 16'h5678, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            do_op(rand_bcd(1'b1), rand_bcd(1'b1), 1'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
        $finish;
    end

endmodule
